sys_cmd_ctrl: RTL and testbench
===============================

// Module: sys_cmd_ctrl
// PURPOSE
//  Second-generation UART system controller. Decodes command frames from the UART RX
//  path, drives register-file writes and reads plus ALU operations, and returns results
//  to the TX FIFO. Multi-byte ALU results are serialised into DATA_W-wide beats and
//  paced by FIFO backpressure. Adds response/ALU timeouts and an error strobe.
// PARAMETERS
//  DATA_W     8   width of RX/TX bytes and register-file data
//  ADDR_W     4   register-file address width
//  FUN_W      4   ALU function-select width
//  ALU_W      16  ALU result width; must be an integer multiple of DATA_W (NB = ALU_W/DATA_W)
//  TMO_CYC    32  max cycles to wait for rd_valid/alu_valid before aborting (>=2)
// PORTS
//  clk          in   1       system clock
//  rst          in   1       synchronous active-low reset
//  rx_data      in   DATA_W  received byte
//  rx_valid     in   1       1-cycle strobe, rx_data valid
//  alu_out      in   ALU_W   ALU result
//  alu_valid    in   1       ALU result valid
//  rd_data      in   DATA_W  register-file read data
//  rd_valid     in   1       register-file read data valid
//  fifo_full    in   1       TX FIFO full
//  alu_fun      out  FUN_W   ALU function select (held)
//  alu_en       out  1       1-cycle ALU start strobe
//  alu_clk_en   out  1       ALU clock gate enable
//  rf_addr      out  ADDR_W  register-file address (held)
//  rf_wr_en     out  1       1-cycle write strobe
//  rf_rd_en     out  1       1-cycle read strobe
//  rf_wr_data   out  DATA_W  register-file write data (held)
//  tx_data      out  DATA_W  byte pushed to TX FIFO
//  tx_valid     out  1       1-cycle FIFO push strobe
//  clk_div_en   out  1       clock-divider enable; constant 1 out of reset
//  busy         out  1       high in any state other than IDLE
//  err          out  1       1-cycle pulse: bad opcode or timeout
// BEHAVIOUR
//  - All outputs are registered. On rst=0 at a clk edge: state=IDLE, all outputs 0
//    except clk_div_en=1. Reset mid-frame abandons the frame; no partial TX beats.
//  - Opcodes are accepted in IDLE on rx_valid: AA=write, BB=read, CC=ALU with operands,
//    DD=ALU without operands. Any other byte -> err pulse next cycle, stay IDLE.
//  - Write: IDLE -AA-> WR_ADDR -byte-> WR_DATA -byte-> IDLE. rf_addr latches
//    byte[ADDR_W-1:0]. On the data byte: rf_wr_data=byte, rf_wr_en=1 for the next cycle.
//  - Read: IDLE -BB-> RD_ADDR -byte-> RD_WAIT. rf_addr latches the byte, rf_rd_en=1 for
//    the next cycle. In RD_WAIT, rd_valid captures rd_data into the TX buffer, NB_cur=1,
//    -> TX_SEND.
//  - ALU: CC -> OPA (byte -> write addr 0) -> OPB (byte -> write addr 1) -> FUN.
//    DD -> FUN directly. In FUN, a byte sets alu_fun=byte[FUN_W-1:0], pulses alu_en, and
//    raises alu_clk_en -> ALU_WAIT. alu_valid captures alu_out, NB_cur=NB, -> TX_SEND.
//    alu_clk_en stays high from FUN acceptance until leaving ALU_WAIT.
//  - TX_SEND: emits beats LS byte first. A beat is pushed (tx_valid=1 for one cycle) only
//    in a cycle where fifo_full=0 is sampled. At most one beat per cycle. fifo_full
//    stalls indefinitely with no timeout. After the last beat -> IDLE.
//  - Timeout: RD_WAIT/ALU_WAIT count cycles from entry. When the count reaches TMO_CYC
//    with no valid: err pulse, -> IDLE, alu_clk_en=0. A valid arriving in the same cycle
//    as expiry wins.
//  - rx_valid is ignored in RD_WAIT, ALU_WAIT and TX_SEND; those bytes are dropped
//    without err.
//  - rd_valid and alu_valid outside their wait states are ignored.
// TESTING
//  1 AA,05,3C -> rf_wr_en 1 cycle, rf_addr=5, rf_wr_data=3C. busy falls. No tx_valid.
//  2 BB,07; rd_valid 3 cycles after rf_rd_en with rd_data=A5 -> one tx_valid, tx_data=A5.
//  3 CC,12,34,00; alu_valid with alu_out=0x0446 -> writes 12@0 and 34@1, alu_en 1 cycle,
//    tx beats 46 then 04.
//  4 DD,02; fifo_full held 10 cycles around the 1st beat -> beats delayed, none lost,
//    order preserved.
//  5 BB,03; no rd_valid -> err exactly TMO_CYC cycles after RD_WAIT entry, IDLE.
//  6 Bytes 7F then AA,01 (reset low mid-frame) -> err for 7F. Reset: outputs cleared,
//    clk_div_en=1. Next AA frame works.

Source files
------------

// File: rtl/sys_cmd_ctrl.sv
// UART system command controller: decodes command frames, drives register-file and ALU
// transactions, and serialises results into the TX FIFO with response timeouts.
module sys_cmd_ctrl #(
    parameter int DATA_W  = 8,
    parameter int ADDR_W  = 4,
    parameter int FUN_W   = 4,
    parameter int ALU_W   = 16,
    parameter int TMO_CYC = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] rx_data,
    input  logic              rx_valid,
    input  logic [ALU_W-1:0]  alu_out,
    input  logic              alu_valid,
    input  logic [DATA_W-1:0] rd_data,
    input  logic              rd_valid,
    input  logic              fifo_full,
    output logic [FUN_W-1:0]  alu_fun,
    output logic              alu_en,
    output logic              alu_clk_en,
    output logic [ADDR_W-1:0] rf_addr,
    output logic              rf_wr_en,
    output logic              rf_rd_en,
    output logic [DATA_W-1:0] rf_wr_data,
    output logic [DATA_W-1:0] tx_data,
    output logic              tx_valid,
    output logic              clk_div_en,
    output logic              busy,
    output logic              err,
    output logic [3:0]        dbg_state
);

    localparam int NB = ALU_W / DATA_W;
    localparam int CW = $clog2(TMO_CYC + 1);
    localparam int BW = $clog2(NB + 1);

    localparam logic [DATA_W-1:0] OP_WR   = DATA_W'(8'hAA);
    localparam logic [DATA_W-1:0] OP_RD   = DATA_W'(8'hBB);
    localparam logic [DATA_W-1:0] OP_ALU  = DATA_W'(8'hCC);
    localparam logic [DATA_W-1:0] OP_ALUN = DATA_W'(8'hDD);
    localparam logic [CW-1:0]     TMO_LAST = CW'(TMO_CYC - 1);

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_WR_ADDR  = 4'd1,
        S_WR_DATA  = 4'd2,
        S_RD_ADDR  = 4'd3,
        S_RD_WAIT  = 4'd4,
        S_OPA      = 4'd5,
        S_OPB      = 4'd6,
        S_FUN      = 4'd7,
        S_ALU_WAIT = 4'd8,
        S_TX_SEND  = 4'd9
    } state_t;

    state_t            state, state_n;
    logic [CW-1:0]     tmo_cnt, tmo_cnt_n;
    logic [ALU_W-1:0]  tx_buf, tx_buf_n;
    logic [BW-1:0]     beat_cnt, beat_cnt_n;
    logic [BW-1:0]     beat_last, beat_last_n;

    logic [FUN_W-1:0]  alu_fun_n;
    logic              alu_en_n, alu_clk_en_n;
    logic [ADDR_W-1:0] rf_addr_n;
    logic              rf_wr_en_n, rf_rd_en_n;
    logic [DATA_W-1:0] rf_wr_data_n, tx_data_n;
    logic              tx_valid_n, busy_n, err_n;

    assign dbg_state = state;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= S_IDLE;
            tmo_cnt    <= '0;
            tx_buf     <= '0;
            beat_cnt   <= '0;
            beat_last  <= '0;
            alu_fun    <= '0;
            alu_en     <= 1'b0;
            alu_clk_en <= 1'b0;
            rf_addr    <= '0;
            rf_wr_en   <= 1'b0;
            rf_rd_en   <= 1'b0;
            rf_wr_data <= '0;
            tx_data    <= '0;
            tx_valid   <= 1'b0;
            busy       <= 1'b0;
            err        <= 1'b0;
            clk_div_en <= 1'b1;
        end else begin
            state      <= state_n;
            tmo_cnt    <= tmo_cnt_n;
            tx_buf     <= tx_buf_n;
            beat_cnt   <= beat_cnt_n;
            beat_last  <= beat_last_n;
            alu_fun    <= alu_fun_n;
            alu_en     <= alu_en_n;
            alu_clk_en <= alu_clk_en_n;
            rf_addr    <= rf_addr_n;
            rf_wr_en   <= rf_wr_en_n;
            rf_rd_en   <= rf_rd_en_n;
            rf_wr_data <= rf_wr_data_n;
            tx_data    <= tx_data_n;
            tx_valid   <= tx_valid_n;
            busy       <= busy_n;
            err        <= err_n;
            clk_div_en <= 1'b1;
        end
    end

    always_comb begin
        state_n      = state;
        tmo_cnt_n    = tmo_cnt;
        tx_buf_n     = tx_buf;
        beat_cnt_n   = beat_cnt;
        beat_last_n  = beat_last;
        alu_fun_n    = alu_fun;
        alu_en_n     = 1'b0;
        alu_clk_en_n = alu_clk_en;
        rf_addr_n    = rf_addr;
        rf_wr_en_n   = 1'b0;
        rf_rd_en_n   = 1'b0;
        rf_wr_data_n = rf_wr_data;
        tx_data_n    = tx_data;
        tx_valid_n   = 1'b0;
        err_n        = 1'b0;

        case (state)
            S_IDLE: begin
                if (rx_valid) begin
                    case (rx_data)
                        OP_WR:   state_n = S_WR_ADDR;
                        OP_RD:   state_n = S_RD_ADDR;
                        OP_ALU:  state_n = S_OPA;
                        OP_ALUN: state_n = S_FUN;
                        default: err_n   = 1'b1;
                    endcase
                end
            end
            S_WR_ADDR: begin
                if (rx_valid) begin
                    rf_addr_n = rx_data[ADDR_W-1:0];
                    state_n   = S_WR_DATA;
                end
            end
            S_WR_DATA: begin
                if (rx_valid) begin
                    rf_wr_data_n = rx_data;
                    rf_wr_en_n   = 1'b1;
                    state_n      = S_IDLE;
                end
            end
            S_RD_ADDR: begin
                if (rx_valid) begin
                    rf_addr_n  = rx_data[ADDR_W-1:0];
                    rf_rd_en_n = 1'b1;
                    tmo_cnt_n  = '0;
                    state_n    = S_RD_WAIT;
                end
            end
            S_RD_WAIT: begin
                // A valid in the expiry cycle takes priority over the timeout.
                if (rd_valid) begin
                    tx_buf_n    = ALU_W'(rd_data);
                    beat_cnt_n  = '0;
                    beat_last_n = '0;
                    state_n     = S_TX_SEND;
                end else if (tmo_cnt == TMO_LAST) begin
                    err_n   = 1'b1;
                    state_n = S_IDLE;
                end else begin
                    tmo_cnt_n = tmo_cnt + CW'(1);
                end
            end
            S_OPA: begin
                if (rx_valid) begin
                    rf_addr_n    = '0;
                    rf_wr_data_n = rx_data;
                    rf_wr_en_n   = 1'b1;
                    state_n      = S_OPB;
                end
            end
            S_OPB: begin
                if (rx_valid) begin
                    rf_addr_n    = ADDR_W'(1);
                    rf_wr_data_n = rx_data;
                    rf_wr_en_n   = 1'b1;
                    state_n      = S_FUN;
                end
            end
            S_FUN: begin
                if (rx_valid) begin
                    alu_fun_n    = rx_data[FUN_W-1:0];
                    alu_en_n     = 1'b1;
                    alu_clk_en_n = 1'b1;
                    tmo_cnt_n    = '0;
                    state_n      = S_ALU_WAIT;
                end
            end
            S_ALU_WAIT: begin
                if (alu_valid) begin
                    tx_buf_n     = alu_out;
                    beat_cnt_n   = '0;
                    beat_last_n  = BW'(NB - 1);
                    alu_clk_en_n = 1'b0;
                    state_n      = S_TX_SEND;
                end else if (tmo_cnt == TMO_LAST) begin
                    err_n        = 1'b1;
                    alu_clk_en_n = 1'b0;
                    state_n      = S_IDLE;
                end else begin
                    tmo_cnt_n = tmo_cnt + CW'(1);
                end
            end
            S_TX_SEND: begin
                // LS byte first; the buffer shifts down one beat per push.
                if (!fifo_full) begin
                    tx_data_n  = tx_buf[DATA_W-1:0];
                    tx_valid_n = 1'b1;
                    tx_buf_n   = tx_buf >> DATA_W;
                    beat_cnt_n = beat_cnt + BW'(1);
                    if (beat_cnt == beat_last) begin
                        state_n = S_IDLE;
                    end
                end
            end
            default: state_n = S_IDLE;
        endcase

        busy_n = (state_n != S_IDLE);
    end

endmodule

// File: tb/tb_sys_cmd_ctrl.sv
// Directed bench for sys_cmd_ctrl: a driver issues frames and pushes expected TX beats,
// register writes, reads and ALU starts into queues that a negedge monitor checks.
module tb_sys_cmd_ctrl;

    localparam int TMO = 32;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [7:0]  rx_data = '0;
    logic        rx_valid = 1'b0;
    logic [15:0] alu_out = '0;
    logic        alu_valid = 1'b0;
    logic [7:0]  rd_data = '0;
    logic        rd_valid = 1'b0;
    logic        fifo_full = 1'b0;
    logic [3:0]  alu_fun;
    logic        alu_en, alu_clk_en;
    logic [3:0]  rf_addr;
    logic        rf_wr_en, rf_rd_en;
    logic [7:0]  rf_wr_data, tx_data;
    logic        tx_valid, clk_div_en, busy, err;
    logic [3:0]  dbg_state;

    int checks = 0;
    int failures = 0;
    int err_cnt = 0;
    int tx_cnt = 0;

    logic [7:0]  exp_tx_q[$];
    logic [11:0] exp_wr_q[$];
    logic [3:0]  exp_rd_q[$];
    logic [3:0]  exp_fun_q[$];

    sys_cmd_ctrl #(.DATA_W(8), .ADDR_W(4), .FUN_W(4), .ALU_W(16), .TMO_CYC(TMO)) dut (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
        .alu_out(alu_out), .alu_valid(alu_valid), .rd_data(rd_data), .rd_valid(rd_valid),
        .fifo_full(fifo_full), .alu_fun(alu_fun), .alu_en(alu_en), .alu_clk_en(alu_clk_en),
        .rf_addr(rf_addr), .rf_wr_en(rf_wr_en), .rf_rd_en(rf_rd_en), .rf_wr_data(rf_wr_data),
        .tx_data(tx_data), .tx_valid(tx_valid), .clk_div_en(clk_div_en), .busy(busy),
        .err(err), .dbg_state(dbg_state)
    );

    // clock / reset
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // monitor / scoreboard
    always @(negedge clk) begin
        if (rst) begin
            if (tx_valid) begin
                tx_cnt++;
                if (exp_tx_q.size() == 0) check("tx_unexpected", {24'd0, tx_data}, 32'hFFFF_FFFF);
                else check("tx_data", {24'd0, tx_data}, {24'd0, exp_tx_q.pop_front()});
            end
            if (rf_wr_en) begin
                if (exp_wr_q.size() == 0) check("wr_unexpected", {20'd0, rf_addr, rf_wr_data}, 32'hFFFF_FFFF);
                else check("rf_write", {20'd0, rf_addr, rf_wr_data}, {20'd0, exp_wr_q.pop_front()});
            end
            if (rf_rd_en) begin
                if (exp_rd_q.size() == 0) check("rd_unexpected", {28'd0, rf_addr}, 32'hFFFF_FFFF);
                else check("rf_read_addr", {28'd0, rf_addr}, {28'd0, exp_rd_q.pop_front()});
            end
            if (alu_en) begin
                if (exp_fun_q.size() == 0) check("alu_unexpected", {28'd0, alu_fun}, 32'hFFFF_FFFF);
                else check("alu_fun", {28'd0, alu_fun}, {28'd0, exp_fun_q.pop_front()});
            end
            if (err) err_cnt++;
        end
    end

    // driver tasks
    task automatic send_byte(input logic [7:0] b);
        @(posedge clk); #1;
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge clk); #1;
        rx_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_rd(input logic [7:0] d);
        rd_data  = d;
        rd_valid = 1'b1;
        @(posedge clk); #1;
        rd_valid = 1'b0;
    endtask

    task automatic pulse_alu(input logic [15:0] d);
        alu_out   = d;
        alu_valid = 1'b1;
        @(posedge clk); #1;
        alu_valid = 1'b0;
    endtask

    task automatic check_reset_state(input string name);
        check({name, "_outs"}, {1'b0, alu_fun, alu_en, alu_clk_en, rf_addr, rf_wr_en, rf_rd_en,
              rf_wr_data, tx_data, tx_valid, busy, err}, 32'd0);
        check({name, "_clk_div_en"}, {31'd0, clk_div_en}, 32'd1);
        check({name, "_state"}, {28'd0, dbg_state}, 32'd0);
    endtask

    initial begin
        int e0;
        int t0;
        int n;

        repeat (3) @(posedge clk);
        #1;
        check_reset_state("reset");
        rst = 1'b1;
        idle(2);

        // 1: register write
        exp_wr_q.push_back({4'h5, 8'h3C});
        send_byte(8'hAA); send_byte(8'h05); send_byte(8'h3C);
        idle(3);
        check("t1_busy", {31'd0, busy}, 32'd0);
        check("t1_rf_addr_held", {28'd0, rf_addr}, 32'h5);

        // 2: register read, data 3 cycles after the strobe
        exp_rd_q.push_back(4'h7);
        exp_tx_q.push_back(8'hA5);
        send_byte(8'hBB); send_byte(8'h07);
        check("t2_busy_wait", {31'd0, busy}, 32'd1);
        repeat (3) @(posedge clk);
        #1;
        pulse_rd(8'hA5);
        idle(4);
        check("t2_idle", {28'd0, dbg_state}, 32'd0);

        // 3: ALU with operands; a stray byte during the wait is dropped
        exp_wr_q.push_back({4'h0, 8'h12});
        exp_wr_q.push_back({4'h1, 8'h34});
        exp_fun_q.push_back(4'h0);
        exp_tx_q.push_back(8'h46);
        exp_tx_q.push_back(8'h04);
        e0 = err_cnt;
        send_byte(8'hCC); send_byte(8'h12); send_byte(8'h34); send_byte(8'h00);
        send_byte(8'hAA);
        check("t3_clk_en_wait", {31'd0, alu_clk_en}, 32'd1);
        pulse_alu(16'h0446);
        check("t3_clk_en_off", {31'd0, alu_clk_en}, 32'd0);
        idle(4);
        check("t3_no_err", err_cnt, e0);
        check("t3_idle", {28'd0, dbg_state}, 32'd0);

        // 4: ALU without operands under FIFO backpressure
        exp_fun_q.push_back(4'h2);
        exp_tx_q.push_back(8'hEF);
        exp_tx_q.push_back(8'hBE);
        send_byte(8'hDD); send_byte(8'h02);
        fifo_full = 1'b1;
        t0 = tx_cnt;
        pulse_alu(16'hBEEF);
        idle(10);
        check("t4_stalled", tx_cnt - t0, 0);
        check("t4_busy_stalled", {31'd0, busy}, 32'd1);
        fifo_full = 1'b0;
        idle(4);
        check("t4_beats", tx_cnt - t0, 2);

        // 5: read timeout
        exp_rd_q.push_back(4'h3);
        e0 = err_cnt;
        send_byte(8'hBB); send_byte(8'h03);
        n = 0;
        while (!err && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        check("t5_tmo_cycles", n, TMO);
        check("t5_busy", {31'd0, busy}, 32'd0);
        idle(2);
        check("t5_err_once", err_cnt - e0, 1);

        // read data arriving in the expiry cycle wins
        exp_rd_q.push_back(4'h4);
        exp_tx_q.push_back(8'h5A);
        e0 = err_cnt;
        send_byte(8'hBB); send_byte(8'h04);
        repeat (TMO - 1) @(posedge clk);
        #1;
        pulse_rd(8'h5A);
        idle(4);
        check("t5b_no_err", err_cnt - e0, 0);

        // 6: bad opcode, then reset mid-frame
        e0 = err_cnt;
        send_byte(8'h7F);
        idle(2);
        check("t6_bad_op_err", err_cnt - e0, 1);
        check("t6_bad_op_idle", {28'd0, dbg_state}, 32'd0);
        send_byte(8'hAA); send_byte(8'h01);
        rst = 1'b0;
        idle(2);
        check_reset_state("t6_reset");
        rst = 1'b1;
        idle(2);
        exp_wr_q.push_back({4'h9, 8'h77});
        send_byte(8'hAA); send_byte(8'h09); send_byte(8'h77);
        idle(3);

        // drain and report
        n = 0;
        while ((exp_tx_q.size() + exp_wr_q.size() + exp_rd_q.size() + exp_fun_q.size()) != 0
               && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        check("pending_tx", exp_tx_q.size(), 0);
        check("pending_wr", exp_wr_q.size(), 0);
        check("pending_rd", exp_rd_q.size(), 0);
        check("pending_fun", exp_fun_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
